// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared ALU/opcode constants and multiply sequencer state type
package cpu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_MUL = 4'b1111;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  typedef enum logic [1:0] {IDLE, RUN, DONE} mul_state_t;

endpackage

// File: rtl/shift_add_datapath.sv
// rtl/shift_add_datapath.sv - radix-2 shift-add multiplier registers (A, B, acc)
module shift_add_datapath #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic             clear,
  input  logic [WIDTH-1:0] a_load,
  input  logic [WIDTH-1:0] b_load,
  output logic [WIDTH-1:0] acc_next
);

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc_q;

  // Value acc takes on this step; exposed so the final sum can be captured directly.
  assign acc_next = b_q[0] ? acc_q + a_q : acc_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else if (load) begin
      a_q   <= a_load;
      b_q   <= b_load;
      acc_q <= '0;
    end else if (step) begin
      acc_q <= acc_next;
      a_q   <= a_q << 1;
      b_q   <= b_q >> 1;
    end
  end

endmodule

// File: rtl/mul_sequencer.sv
// rtl/mul_sequencer.sv - execute-stage multi-cycle MUL controller with pipeline stall
module mul_sequencer
  import cpu_pkg::*;
#(
  parameter int         WIDTH    = 32,
  parameter logic [3:0] MUL_CODE = ALU_MUL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       ALUControlE,
  input  logic             validE,
  input  logic             flushE,
  input  logic [WIDTH-1:0] srcAE,
  input  logic [WIDTH-1:0] srcBE,
  output logic             stallMul,
  output logic [WIDTH-1:0] mulResultE,
  output logic             mulDone,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  mul_state_t       state, next_state;
  logic [CW-1:0]    cnt;
  logic             start;
  logic             load;
  logic             step;
  logic             clear;
  logic [WIDTH-1:0] acc_next;

  shift_add_datapath #(.WIDTH(WIDTH)) u_dp (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .step     (step),
    .clear    (clear),
    .a_load   (srcAE),
    .b_load   (srcBE),
    .acc_next (acc_next)
  );

  always_comb begin
    next_state = state;
    stallMul   = 1'b0;
    load       = 1'b0;
    step       = 1'b0;
    clear      = 1'b0;
    start      = (state == IDLE) && validE && !flushE && (ALUControlE == MUL_CODE);
    case (state)
      IDLE: begin
        stallMul = start;
        if (start) begin
          load       = 1'b1;
          next_state = RUN;
        end
      end
      RUN: begin
        stallMul = 1'b1;
        // A flush outranks completion, even on the final step.
        if (flushE) begin
          clear      = 1'b1;
          next_state = IDLE;
        end else begin
          step = 1'b1;
          if (cnt == '0) next_state = DONE;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      mulResultE <= '0;
    end else begin
      state <= next_state;
      if (load)
        cnt <= CW'(WIDTH - 1);
      else if (step)
        cnt <= cnt - 1'b1;
      if (step && cnt == '0)
        mulResultE <= acc_next;
    end
  end

  assign mulDone = (state == DONE);
  assign busy    = (state == RUN);

endmodule

// File: doc/mul_sequencer.md
Name: mul_sequencer

Overview:
- Multi-cycle controller for the MUL operation (ALU control code 4'b1111) in the execute stage of the 5-stage pipeline.
- Detects a MUL in E, latches its operands, and runs a radix-2 shift-add multiply over WIDTH cycles.
- While the multiply runs, it holds the pipeline with a stall that gates the F/D/E registers, then presents the low WIDTH bits of the product for one cycle.
- The single-cycle ALU still handles every other code; the E-stage result mux selects mulResultE when mulDone=1.

Parameters:
- WIDTH, 32, operand and result width.
- MUL_CODE, 4'b1111, ALUControlE value that starts a multiply.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- ALUControlE  in  4  ALU control of the instruction in E.
- validE  in  1  E holds a real instruction (not a bubble).
- flushE  in  1  kill the instruction in E; aborts a running multiply.
- srcAE  in  WIDTH  multiplicand.
- srcBE  in  WIDTH  multiplier.
- stallMul  out  1  hold F, D and E registers; must not bubble M.
- mulResultE  out  WIDTH  low WIDTH bits of srcAE*srcBE, unsigned.
- mulDone  out  1  mulResultE valid this cycle; the pipeline advances.
- busy  out  1  state is RUN.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high on rst.
- Reset values: state=IDLE, stallMul=0, mulDone=0, busy=0, mulResultE=0, counter=0.
- Start condition: start = (state==IDLE) & validE & ~flushE & (ALUControlE==MUL_CODE).

States:
- IDLE:
  - stallMul = start, combinational, so E holds in the detect cycle.
  - On start: latch A=srcAE, B=srcBE, acc=0, cnt=WIDTH-1, then go to RUN.
- RUN:
  - stallMul=1, busy=1.
  - Each cycle: if B[0] then acc += A (mod 2^WIDTH); A <<= 1; B >>= 1; cnt -= 1.
  - When cnt==0 after the final step, go to DONE.
  - flushE=1 in RUN: go to IDLE next cycle, acc discarded, mulDone not asserted, mulResultE unchanged.
- DONE:
  - stallMul=0, mulDone=1, mulResultE=acc (registered on entry to DONE).
  - Always returns to IDLE next cycle. The MUL is still in E during DONE and must not retrigger, because start is evaluated only in IDLE.

Timing:
- Latency: detect cycle T (IDLE, stall=1), RUN for T+1..T+WIDTH (stall=1), DONE at T+WIDTH+1 (stall=0, mulDone=1).
- stallMul is high for exactly WIDTH+1 consecutive cycles.

Boundary conditions:
- Back-to-back MULs: the second reaches E in the cycle after DONE and starts from IDLE with no gap cycle lost.
- Zero operand: no early exit; latency is still fixed.
- Overflow: bits above WIDTH are dropped.
- Output hold: mulResultE stays stable after DONE until the next entry to DONE or reset.
- validE=0 with ALUControlE==MUL_CODE: no start.
- flushE in the detect cycle: no start, stallMul=0.
- rst mid-RUN: IDLE on the next edge, stall drops, all outputs return to reset values.
- Non-MUL codes: no effect; the block stays IDLE with stallMul=0.

Decomposition:
- Shared package cpu_pkg:
  - ALU control constants: ALU_AND=4'b0000, ALU_OR=4'b0001, ALU_ADD=4'b0010, ALU_SUB=4'b0110, ALU_MUL=4'b1111.
  - State enum mul_state_t {IDLE, RUN, DONE}.
  - Opcode constants for R-type, BEQ, BNE, ADDI, LW and SW.
- Sub-module shift_add_datapath: A/B/acc registers with load, step and clear, driven by the FSM.
- The FSM and counter stay in mul_sequencer.

Test Plan:
- Basic multiply: ALUControlE=1111, validE=1, srcAE=7, srcBE=6 at cycle T.
  - stallMul=1 for T..T+32.
  - At T+33: mulDone=1, stallMul=0, mulResultE=42.
- Overflow wrap: srcAE=32'hFFFF_FFFF, srcBE=2 → mulResultE=32'hFFFF_FFFE. Also srcAE=32'h8000_0000, srcBE=2 → 0.
- Non-MUL codes: ALUControlE=0010, then 0110, with validE=1 → stallMul=0 every cycle, mulDone never asserted.
- Abort by flush: start 3*5, then assert flushE at T+10.
  - IDLE at T+11, stallMul=0 from T+11.
  - mulDone never asserted; mulResultE keeps its prior value.
  - Also: rst at T+10 → mulResultE=0.
- Back-to-back: 3*4 followed immediately by 9*9 in E.
  - First mulDone at T+33 with result 12.
  - Second start at T+34, mulDone at T+67 with result 81.
  - No retrigger during DONE.
- Gated starts:
  - validE=0 with ALUControlE=1111 → no start.
  - flushE=1 in the detect cycle → no start, stallMul=0.
